// File: rtl/comb_sweep_ctrl.sv
// Handshaked sweep sequencer: drives a 4-input combinational primitive through all 16 vectors
// and captures its truth table and ones count. Define COMB_SWEEP_CHECK_EN to compare against EXPECTED.
module comb_sweep_ctrl #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        y_in,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic [4:0]  ones,
    output logic        mismatch,
    output logic [3:0]  fail_idx
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned VEC_W    = 4;
    localparam int unsigned ONES_W   = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(15);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [VEC_W-1:0]   abcd_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [15:0]        tt_nxt;
    logic [ONES_W-1:0]  ones_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort only matters while a sweep is running
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = DRIVE;
            DRIVE: begin
                if (abort)                 state_nxt = IDLE;
                else if (cnt == CNT_LAST)  state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort)                 state_nxt = IDLE;
                else if (abcd == VEC_LAST) state_nxt = DONE;
                else                       state_nxt = DRIVE;
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered datapath and outputs
    always_comb begin
        cnt_nxt  = cnt;
        abcd_nxt = abcd;
        tt_nxt   = tt;
        ones_nxt = ones;
        busy_nxt = (state_nxt == DRIVE) || (state_nxt == SAMPLE);
        done_nxt = (state_nxt == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt  = '0;
                    abcd_nxt = '0;
                    tt_nxt   = '0;
                    ones_nxt = '0;
                end
            end
            DRIVE: begin
                if (abort) abcd_nxt = '0;
                else       cnt_nxt  = cnt + CNT_W'(1);
            end
            SAMPLE: begin
                if (abort) begin
                    abcd_nxt = '0;
                end else begin
                    tt_nxt[abcd] = y_in;
                    ones_nxt     = ones + ONES_W'(y_in);
                    if (abcd != VEC_LAST) begin
                        abcd_nxt = abcd + VEC_W'(1);
                        cnt_nxt  = '0;
                    end
                end
            end
            DONE:    abcd_nxt = '0;
            default: abcd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            abcd <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            tt   <= '0;
            ones <= '0;
        end else begin
            cnt  <= cnt_nxt;
            abcd <= abcd_nxt;
            busy <= busy_nxt;
            done <= done_nxt;
            tt   <= tt_nxt;
            ones <= ones_nxt;
        end
    end

`ifdef COMB_SWEEP_CHECK_EN
    logic sample_en;
    logic clr_chk;

    assign sample_en = (state == SAMPLE) && !abort;
    assign clr_chk   = (state == IDLE) && start;

    // Sticky mismatch flag; fail_idx latches only the first miss
    always_ff @(posedge clk) begin
        if (rst || clr_chk) begin
            mismatch <= 1'b0;
            fail_idx <= '0;
        end else if (sample_en && (y_in != EXPECTED[abcd])) begin
            mismatch <= 1'b1;
            if (!mismatch) fail_idx <= abcd;
        end
    end
`else
    // EXPECTED only matters when checking is compiled in
    assign mismatch = |(EXPECTED & 16'h0000);
    assign fail_idx = 4'd0;
`endif

endmodule
